// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, issue-unit state encoding and ALU select codes
package alu_pkg;

  localparam int ALU_WIDTH = 64;
  localparam int ALU_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Select codes understood by the combinational ALU beside the issue unit
  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_MUL  = 4'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_DIV  = 4'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_SHL  = 4'd4;
  localparam logic [ALU_SEL_W-1:0] ALU_SHR  = 4'd5;
  localparam logic [ALU_SEL_W-1:0] ALU_ROL  = 4'd6;
  localparam logic [ALU_SEL_W-1:0] ALU_ROR  = 4'd7;
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'd8;
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'd9;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'd10;
  localparam logic [ALU_SEL_W-1:0] ALU_NOR  = 4'd11;
  localparam logic [ALU_SEL_W-1:0] ALU_NAND = 4'd12;
  localparam logic [ALU_SEL_W-1:0] ALU_XNOR = 4'd13;
  localparam logic [ALU_SEL_W-1:0] ALU_GT   = 4'd14;
  localparam logic [ALU_SEL_W-1:0] ALU_EQ   = 4'd15;

endpackage

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - issue stage: registers commands onto the ALU and hands back its result
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SEL_W = ALU_SEL_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_op1,
  input  logic [WIDTH-1:0] cmd_op2,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [SEL_W-1:0] alu_select,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic [CNT_W-1:0] op_count
);

  state_t           state;
  logic [WIDTH-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b1;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_select <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_carry  <= 1'b0;
      op_count   <= '0;
      acc        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_op1    <= cmd_chain ? acc : cmd_op1;
            alu_op2    <= cmd_op2;
            alu_select <= cmd_sel;
            cmd_ready  <= 1'b0;
            state      <= ST_EXEC;
          end
        end
        // ALU inputs have been stable for a full cycle; capture its settled output
        ST_EXEC: begin
          res_data  <= alu_out;
          res_carry <= alu_carry_out;
          acc       <= alu_out;
          res_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - scoreboard bench for alu_issue_unit with a behavioural ALU beside it
module tb_alu_issue_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [63:0] cmd_op1, cmd_op2;
  logic [3:0]  cmd_sel;
  logic        cmd_chain;
  logic        res_ready;

  logic        cmd_ready, res_valid, res_carry, alu_carry;
  logic [63:0] alu_op1, alu_op2, alu_out, res_data;
  logic [3:0]  alu_select;
  logic [15:0] op_count;

  logic        cmd_ready4, res_valid4, res_carry4, alu_carry4;
  logic [63:0] alu_op1_4, alu_op2_4, alu_out4, res_data4;
  logic [3:0]  alu_select4;
  logic [3:0]  op_count4;

  int pass_cnt = 0;
  int total_cnt = 0;
  int low_cnt = 0;
  logic sweep_on = 1'b0;
  logic [64:0] exp_q [$];
  logic [63:0] sweep_exp [16];
  logic [63:0] held_data;

  always #5 clk = ~clk;

  function automatic logic [64:0] alu_model(input logic [63:0] a, input logic [63:0] b, input logic [3:0] s);
    logic [64:0] r;
    r = '0;
    case (s)
      ALU_ADD:  r = {1'b0, a} + {1'b0, b};
      ALU_SUB:  r[63:0] = a - b;
      ALU_MUL:  r[63:0] = a * b;
      ALU_DIV:  r[63:0] = (b == 64'd0) ? 64'd0 : a / b;
      ALU_SHL:  r[63:0] = a << 1;
      ALU_SHR:  r[63:0] = a >> 1;
      ALU_ROL:  r[63:0] = {a[62:0], a[63]};
      ALU_ROR:  r[63:0] = {a[0], a[63:1]};
      ALU_AND:  r[63:0] = a & b;
      ALU_OR:   r[63:0] = a | b;
      ALU_XOR:  r[63:0] = a ^ b;
      ALU_NOR:  r[63:0] = ~(a | b);
      ALU_NAND: r[63:0] = ~(a & b);
      ALU_XNOR: r[63:0] = ~(a ^ b);
      ALU_GT:   r[63:0] = {63'd0, a > b};
      ALU_EQ:   r[63:0] = {63'd0, a == b};
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_out}   = alu_model(alu_op1, alu_op2, alu_select);
  assign {alu_carry4, alu_out4} = alu_model(alu_op1_4, alu_op2_4, alu_select4);

  alu_issue_unit #(.WIDTH(64), .SEL_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_select(alu_select),
    .alu_out(alu_out), .alu_carry_out(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .op_count(op_count)
  );

  // Narrow-counter twin fed the same stimulus, used for the wrap check
  alu_issue_unit #(.WIDTH(64), .SEL_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
    .alu_op1(alu_op1_4), .alu_op2(alu_op2_4), .alu_select(alu_select4),
    .alu_out(alu_out4), .alu_carry_out(alu_carry4),
    .res_valid(res_valid4), .res_ready(res_ready),
    .res_data(res_data4), .res_carry(res_carry4), .op_count(op_count4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] op1, input logic [63:0] op2, input logic [3:0] sel,
                      input logic chain, input logic [63:0] exp_data, input logic exp_carry);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op1 = op1; cmd_op2 = op2; cmd_sel = sel; cmd_chain = chain;
    exp_q.push_back({exp_carry, exp_data});
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("accept_timeout", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_empty;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) check("result_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_result: got %h expected none", res_data);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("res_data", res_data, e[63:0]);
        check("res_carry", 64'(res_carry), 64'(e[64]));
      end
    end
    if (sweep_on && !cmd_ready) low_cnt++;
  end

  initial begin
    sweep_exp = '{64'h194A, 64'hFFFF_FFFF_FFFF_F4EA, 64'h8128E0, 64'h0,
                  64'h0E34, 64'h038D, 64'h0E34, 64'h038D,
                  64'h0210, 64'h173A, 64'h152A, 64'hFFFF_FFFF_FFFF_E8C5,
                  64'hFFFF_FFFF_FFFF_FDEF, 64'hFFFF_FFFF_FFFF_EAD5, 64'h0, 64'h0};
    rst = 1'b1; cmd_valid = 1'b0; cmd_op1 = '0; cmd_op2 = '0; cmd_sel = '0;
    cmd_chain = 1'b0; res_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_alu_op1", alu_op1, 64'd0);
    check("rst_res_data", res_data, 64'd0);

    // Chain with no prior result uses zero as Op1
    send(64'hDEAD, 64'h7, ALU_ADD, 1'b1, 64'h7, 1'b0);
    check("chain_zero_op1", alu_op1, 64'd0);
    wait_empty();

    // Single op with latency check
    send(64'h071A, 64'h1230, ALU_ADD, 1'b0, 64'h194A, 1'b0);
    check("lat_valid_n", 64'(res_valid), 64'd0);
    tick();
    check("lat_valid_n1", 64'(res_valid), 64'd1);
    tick();
    check("single_op_count", 64'(op_count), 64'd2);

    // Reset while EXEC: in-flight op discarded and not counted
    cmd_valid = 1'b1; cmd_op1 = 64'h1234; cmd_op2 = 64'h1; cmd_sel = ALU_ADD; cmd_chain = 1'b0;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_op_count", 64'(op_count), 64'd0);
    check("mid_rst_alu_op1", alu_op1, 64'd0);
    tick();

    // Select sweep, back to back
    sweep_on = 1'b1;
    for (int i = 0; i < 16; i++)
      send(64'h071A, 64'h1230, 4'(i), 1'b0, sweep_exp[i], 1'b0);
    wait_empty();
    sweep_on = 1'b0;
    check("sweep_op_count", 64'(op_count), 64'd16);
    check("wrap_op_count4", 64'(op_count4), 64'd0);
    check("sweep_ready_low", 64'(low_cnt), 64'd32);

    // Back-pressure with a carry-producing add
    res_ready = 1'b0;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, ALU_ADD, 1'b0, 64'h0, 1'b1);
    tick();
    check("bp_res_valid", 64'(res_valid), 64'd1);
    held_data = res_data;
    cmd_valid = 1'b1; cmd_op1 = 64'hF0F0; cmd_op2 = 64'h0FF0; cmd_sel = ALU_XOR; cmd_chain = 1'b0;
    exp_q.push_back({1'b0, 64'hFF00});
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", res_data, held_data);
      check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      check("bp_alu_select", 64'(alu_select), 64'(ALU_ADD));
    end
    res_ready = 1'b1;
    tick();
    check("bp_ready_after", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    check("bp_accepted", 64'(alu_select), 64'(ALU_XOR));
    wait_empty();

    // Accumulator chaining
    send(64'h5, 64'h3, ALU_ADD, 1'b0, 64'h8, 1'b0);
    wait_empty();
    send(64'hAAAA, 64'h1, ALU_ADD, 1'b1, 64'h9, 1'b0);
    check("chain_op1", alu_op1, 64'h8);
    wait_empty();
    tick();
    check("final_op_count", 64'(op_count), 64'd20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
